uart_rx_fifo: RTL and testbench

Parametrised UART receiver with 16x oversampling, configurable frame format (data bits, parity, stop bits) and a receive FIFO with valid/ready output. It supersedes the fixed 8N1 receive path behind the serial line in the top-level design. It adds per-word error flags, RTS flow control derived from FIFO fill level, overrun reporting, and break detection.

---
 rtl/uart_rx_fifo.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampling, DATA_BITS/PARITY/STOP_BITS frame) feeding a first-word-fall-through receive FIFO.
// Latency: word visible on m_*_o the cycle after the mid-point of the final stop bit; level/rts_o update one cycle after push/pop.
// Backpressure: m_ready_i pops the head; a word arriving at a full FIFO with no pop is dropped (overrun_o); rts_o drops near full.
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int RTS_MARGIN  = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               rx_i,
  output logic [DATA_BITS-1:0]               m_data_o,
  output logic                               m_perr_o,
  output logic                               m_ferr_o,
  output logic                               m_valid_o,
  input  logic                               m_ready_i,
  output logic                               rts_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level_o,
  output logic                               overrun_o,
  output logic                               break_o
);

  localparam int OS_DIV = CLK_FREQ_HZ / (BAUD_RATE * 16);
  localparam int CW     = $clog2(OS_DIV + 1);
  localparam logic [CW-1:0] OS_LAST = CW'(OS_DIV - 1);
  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic       STOP_LAST = (STOP_BITS == 2);
  localparam logic       PAR_EXP   = (PARITY == 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = DATA_BITS + 2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BRK_WAIT
  } state_t;

  // receiver state
  logic                 r_sync1, r_sync2, r_rxs_d;
  logic                 w_rxs;
  state_t               r_state;
  logic [CW-1:0]        r_os_cnt;
  logic [3:0]           r_s;
  logic                 r_v7, r_v8;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit, r_ferr, r_stop_cnt, r_brk;

  logic w_tick, w_mid, w_end, w_vote;
  logic w_push, w_ferr_fin, w_perr, w_break;
  logic [WW-1:0] w_push_dat;

  // FIFO state
  logic [WW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level, w_level_nxt;
  logic          r_rts, r_ovr;
  logic          w_empty, w_full, w_pop, w_wr_en;
  logic [WW-1:0] w_head;

  assign w_rxs  = r_sync2;
  assign w_tick = (r_os_cnt == OS_LAST);
  assign w_mid  = w_tick && (r_s == 4'd9);
  assign w_end  = w_tick && (r_s == 4'd15);
  // majority of the s=7 and s=8 samples with the live s=9 sample
  assign w_vote = (r_v7 & r_v8) | (r_v7 & w_rxs) | (r_v8 & w_rxs);

  assign w_push     = (r_state == ST_STOP) && w_mid && (r_stop_cnt == STOP_LAST);
  assign w_ferr_fin = r_ferr | ~w_vote;
  assign w_perr     = (PARITY != 0) && ((^r_shift ^ r_par_bit) != PAR_EXP);
  assign w_break    = w_ferr_fin && (r_shift == '0) && ((PARITY == 0) || !r_par_bit);
  assign w_push_dat = {w_ferr_fin, w_perr, r_shift};

  // two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_rxs_d <= r_sync2;
    end
  end

  // oversample divider, parked at zero while no frame is in flight
  always_ff @(posedge clk_i) begin
    if (rst_i || r_state == ST_IDLE || r_state == ST_BRK_WAIT) begin
      r_os_cnt <= '0;
    end else if (w_tick) begin
      r_os_cnt <= '0;
    end else begin
      r_os_cnt <= r_os_cnt + CW'(1);
    end
  end

  // frame FSM: sample index, voting, shifting, error flags and break pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_s        <= 4'd0;
      r_v7       <= 1'b1;
      r_v8       <= 1'b1;
      r_bit_cnt  <= 4'd0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_ferr     <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      r_brk <= 1'b0;
      if (w_tick) begin
        r_s <= r_s + 4'd1;
        if (r_s == 4'd7) r_v7 <= w_rxs;
        if (r_s == 4'd8) r_v8 <= w_rxs;
      end
      case (r_state)
        ST_IDLE: begin
          r_s <= 4'd0;
          if (r_rxs_d && !w_rxs) r_state <= ST_START;
        end
        ST_START: begin
          if (w_mid && w_vote) begin
            r_state <= ST_IDLE;
          end else if (w_end) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= 4'd0;
          end
        end
        ST_DATA: begin
          if (w_mid) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_end) begin
            if (r_bit_cnt == BIT_LAST) begin
              r_state    <= (PARITY != 0) ? ST_PARITY : ST_STOP;
              r_stop_cnt <= 1'b0;
              r_ferr     <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_mid) r_par_bit <= w_vote;
          if (w_end) r_state <= ST_STOP;
        end
        ST_STOP: begin
          if (w_mid) begin
            if (r_stop_cnt == STOP_LAST) begin
              r_brk   <= w_break;
              r_state <= w_break ? ST_BRK_WAIT : ST_IDLE;
            end else begin
              r_ferr <= w_ferr_fin;
            end
          end else if (w_end) begin
            r_stop_cnt <= 1'b1;
          end
        end
        ST_BRK_WAIT: begin
          if (w_rxs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // FIFO status; a simultaneous pop frees the slot a full-FIFO push needs
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && m_ready_i;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  // next occupancy, shared by the level and rts registers so they stay coherent
  always_comb begin
    w_level_nxt = r_level;
    if (w_wr_en && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (w_pop && !w_wr_en) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  // storage array; contents beyond the pointers are don't-care so it has no reset
  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_push_dat;
  end

  // pointers, level, rts and overrun pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_rts    <= 1'b1;
      r_ovr    <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level <= w_level_nxt;
      r_rts   <= (LW'(FIFO_DEPTH) - w_level_nxt) > LW'(RTS_MARGIN);
      r_ovr   <= w_push && w_full && !w_pop;
    end
  end

  // head word is forced to zero while empty so stale entries never leak out
  assign {m_ferr_o, m_perr_o, m_data_o} = w_empty ? '0 : w_head;
  assign m_valid_o    = !w_empty;
  assign fifo_level_o = r_level;
  assign rts_o        = r_rts;
  assign overrun_o    = r_ovr;
  assign break_o      = r_brk;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: 7E2 frames, 4-entry FIFO, 4 clocks per oversample tick.
// Expected words come from the frame rules; a monitor pops them as the DUT hands words out.
module tb_uart_rx_fifo;

  localparam int CLK_HZ  = 640_000;
  localparam int BAUD    = 10_000;
  localparam int DB      = 7;
  localparam int PAR     = 2;
  localparam int SB      = 2;
  localparam int DEPTH   = 4;
  localparam int MARGIN  = 1;
  localparam int BIT_CYC = (CLK_HZ / (BAUD * 16)) * 16;
  localparam int NB      = 1 + DB + 1 + SB + 2;
  localparam int LW      = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          ferr;
    logic          perr;
    logic [DB-1:0] d;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          rx_i = 1'b1;
  logic          m_ready_i = 1'b0;
  logic [DB-1:0] m_data_o;
  logic          m_perr_o, m_ferr_o, m_valid_o, rts_o, overrun_o, break_o;
  logic [LW-1:0] fifo_level_o;

  word_t exp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    brk_cnt = 0;
  int    ovr_cnt = 0;
  int    exp_brk = 0;
  int    exp_ovr = 0;
  bit    rand_rdy = 1'b0;
  bit    cal_on = 1'b0;
  int    cal_k = 0;
  int    pulse_at = -1;

  uart_rx_fifo #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(DB), .PARITY(PAR),
    .STOP_BITS(SB), .FIFO_DEPTH(DEPTH), .RTS_MARGIN(MARGIN)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i),
    .m_data_o(m_data_o), .m_perr_o(m_perr_o), .m_ferr_o(m_ferr_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .rts_o(rts_o),
    .fifo_level_o(fifo_level_o), .overrun_o(overrun_o), .break_o(break_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // monitor: counts pulses and checks every word the DUT hands out
  always @(negedge clk) begin
    word_t e;
    #2;
    if (!rst_i) begin
      if (break_o) brk_cnt++;
      if (overrun_o) ovr_cnt++;
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", int'(m_data_o), int'(e.d));
          check("pop_perr", int'(m_perr_o), int'(e.perr));
          check("pop_ferr", int'(m_ferr_o), int'(e.ferr));
        end
      end
    end
  end

  // drive one frame bit by bit; per-cycle hooks randomise ready, calibrate or pulse ready
  task automatic send_frame(input logic [DB-1:0] d, input logic pbit, input logic s1, input logic s2);
    logic v [NB];
    int   cyc;
    int   lvl0;
    v[0] = 1'b0;
    for (int i = 0; i < DB; i++) v[1+i] = d[i];
    v[DB+1] = pbit;
    v[DB+2] = s1;
    v[DB+3] = s2;
    v[DB+4] = 1'b1;
    v[DB+5] = 1'b1;
    @(negedge clk);
    cyc  = 0;
    lvl0 = int'(fifo_level_o);
    for (int b = 0; b < NB; b++) begin
      rx_i = v[b];
      for (int c = 0; c < BIT_CYC; c++) begin
        @(negedge clk);
        cyc++;
        if (rand_rdy) m_ready_i = 1'($urandom_range(0, 1));
        if (cal_on && cal_k == 0 && int'(fifo_level_o) != lvl0) cal_k = cyc;
        if (cyc == pulse_at) m_ready_i = 1'b1;
        if (cyc == pulse_at + 1) m_ready_i = 1'b0;
      end
    end
  endtask

  // reference: even parity over data+parity bit, ferr on any low stop bit,
  // break when everything before the stop bits is low and a stop bit is low
  task automatic frame(input logic [DB-1:0] d, input bit bad_par, input logic s1, input logic s2);
    word_t w;
    logic  pbit;
    pbit   = 1'(($countones(d) % 2 != 0) ^ bad_par);
    w.d    = d;
    w.perr = ($countones({d, pbit}) % 2) != 0;
    w.ferr = !(s1 && s2);
    if (w.ferr && d == '0 && !pbit) exp_brk++;
    if (exp_q.size() < DEPTH || pulse_at >= 0) exp_q.push_back(w);
    else exp_ovr++;
    send_frame(d, pbit, s1, s2);
  endtask

  task automatic check_fill(input string tag);
    check({tag, "_level"}, int'(fifo_level_o), exp_q.size());
    check({tag, "_rts"}, int'(rts_o), int'((DEPTH - exp_q.size()) > MARGIN));
  endtask

  task automatic drain(input string tag);
    m_ready_i = 1'b1;
    repeat (20) @(negedge clk);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    check({tag, "_level0"}, int'(fifo_level_o), 0);
    check({tag, "_rts1"}, int'(rts_o), 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, int'(m_valid_o), 0);
    check({tag, "_data"}, int'(m_data_o), 0);
    check({tag, "_perr"}, int'(m_perr_o), 0);
    check({tag, "_ferr"}, int'(m_ferr_o), 0);
    check({tag, "_level"}, int'(fifo_level_o), 0);
    check({tag, "_rts"}, int'(rts_o), 1);
    check({tag, "_overrun"}, int'(overrun_o), 0);
    check({tag, "_break"}, int'(break_o), 0);
  endtask

  initial begin
    logic [DB-1:0] rd;
    repeat (5) @(negedge clk);
    check_reset("reset");
    rst_i = 1'b0;
    repeat (2 * BIT_CYC) @(negedge clk);

    // clean frames, consumer always ready
    m_ready_i = 1'b1;
    frame(7'h41, 0, 1, 1);  check("basic1_rts", int'(rts_o), 1);
    frame(7'h2A, 0, 1, 1);  check("basic2_rts", int'(rts_o), 1);
    frame(7'h01, 0, 1, 1);  check("basic3_rts", int'(rts_o), 1);
    drain("basic");

    // parity error then correct parity
    frame(7'h55, 1, 1, 1);
    frame(7'h55, 0, 1, 1);
    drain("parity");

    // framing error on nonzero data is not a break
    frame(7'h3C, 0, 0, 0);
    drain("framing");
    check("framing_no_break", brk_cnt, exp_brk);

    // long break: one zero word with ferr, one pulse, nothing more while low
    exp_q.push_back('{ferr: 1'b1, perr: 1'b0, d: '0});
    exp_brk++;
    @(negedge clk);
    rx_i = 1'b0;
    repeat (30 * BIT_CYC) @(negedge clk);
    check("break_pulses", brk_cnt, exp_brk);
    check("break_word_popped", exp_q.size(), 0);
    rx_i = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clk);
    check("break_once", brk_cnt, exp_brk);

    // short glitch must not start a frame
    @(negedge clk);
    rx_i = 1'b0;
    repeat (6) @(negedge clk);
    rx_i = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clk);
    check("glitch_level", int'(fifo_level_o), 0);
    check("glitch_valid", int'(m_valid_o), 0);
    frame(7'h12, 0, 1, 1);
    drain("after_glitch");

    // fill with no consumer, then overflow
    m_ready_i = 1'b0;
    cal_on = 1'b1;
    frame(7'h01, 0, 1, 1);  check_fill("fill1");
    cal_on = 1'b0;
    frame(7'h02, 0, 1, 1);  check_fill("fill2");
    frame(7'h03, 0, 1, 1);  check_fill("fill3");
    frame(7'h04, 0, 1, 1);  check_fill("fill4");
    frame(7'h05, 0, 1, 1);  check_fill("fill5");
    check("overrun_pulse", ovr_cnt, exp_ovr);
    check("overrun_expected", exp_ovr, 1);

    // push into a full FIFO in the same cycle as a pop
    if (cal_k > 0) begin
      pulse_at = cal_k - 1;
      frame(7'h06, 0, 1, 1);
      pulse_at = -1;
      check_fill("full_pop");
      check("full_pop_no_overrun", ovr_cnt, exp_ovr);
    end else begin
      check("calibration_found", 0, 1);
    end
    drain("fill");

    // reset mid-frame flushes the FIFO and aborts the frame
    m_ready_i = 1'b0;
    frame(7'h2A, 0, 1, 1);
    check_fill("pre_reset");
    @(negedge clk);
    rx_i = 1'b0;
    repeat (4 * BIT_CYC) @(negedge clk);
    rst_i = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    check_reset("midreset");
    @(negedge clk);
    rst_i = 1'b0;
    repeat (2 * BIT_CYC) @(negedge clk);
    m_ready_i = 1'b1;
    frame(7'h33, 0, 1, 1);
    drain("post_reset");

    // randomised frames with random consumer readiness
    rand_rdy = 1'b1;
    for (int n = 0; n < 14; n++) begin
      rd = DB'($urandom_range(0, 127));
      if (n % 5 == 4) rd = '0;
      frame(rd, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    rand_rdy = 1'b0;
    drain("random");
    check("random_breaks", brk_cnt, exp_brk);
    check("random_overruns", ovr_cnt, exp_ovr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
